unidade_controle: RTL and testbench



---
 rtl/unidade_controle_pkg.sv | 54 +++++
 rtl/unidade_controle.sv | 136 +++++++++++++
 tb/tb_unidade_controle.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared constants for the accumulator processor control unit:
// instruction opcodes, ULA operation selects and the sequencer states.
package unidade_controle_pkg;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ULA operation selects (X = accumulator, Y = memory data)
    localparam logic [2:0] ULA_PASSY = 3'b000;
    localparam logic [2:0] ULA_ADD   = 3'b001;
    localparam logic [2:0] ULA_OR    = 3'b010;
    localparam logic [2:0] ULA_AND   = 3'b011;
    localparam logic [2:0] ULA_NOT   = 3'b100;
    localparam logic [2:0] ULA_SUB   = 3'b101;

    // Sequencer states
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        LOADIR  = 4'd2,
        DECODE  = 4'd3,
        MEMADDR = 4'd4,
        MEMEXEC = 4'd5,
        STORE   = 4'd6,
        ALUX    = 4'd7,
        HALT    = 4'd8
    } state_t;

    // ULA select for the memory-operand instructions executed in MEMEXEC
    function automatic logic [2:0] ula_sel_for(input logic [3:0] op);
        logic [2:0] sel;
        case (op)
            OP_LDA:  sel = ULA_PASSY;
            OP_ADD:  sel = ULA_ADD;
            OP_OR:   sel = ULA_OR;
            OP_AND:  sel = ULA_AND;
            OP_SUB:  sel = ULA_SUB;
            default: sel = ULA_PASSY;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/unidade_controle.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
// Holds PC and IR; all datapath controls are Moore outputs of the state,
// PC and IR registers, so nothing depends combinationally on run or flags.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [15:0]           q_MEM,
    input  logic                  q_N,
    input  logic                  q_Z,
    output logic                  we_MEM,
    output logic [15:0]           addr,
    output logic                  write_AC,
    output logic [2:0]            select_ULA,
    output logic                  writeNZ,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_q,
    output logic [15:0]           ir_q
);

    localparam logic [ADDR_WIDTH-1:0] START_PC = START_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [3:0]            opcode_s;
    logic [ADDR_WIDTH-1:0] operand_s;

    assign opcode_s  = ir_q[15:12];
    assign operand_s = ir_q[ADDR_WIDTH-1:0];

    // Sequencer state, PC and IR; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            ir_q    <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= LOADIR;
                end
                LOADIR: begin
                    // memory read data for PC is valid now (registered read)
                    ir_q    <= q_MEM;
                    pc_q    <= pc_q + PC_ONE;
                    state_q <= DECODE;
                end
                DECODE: begin
                    case (opcode_s)
                        OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB: state_q <= MEMADDR;
                        OP_STA: state_q <= STORE;
                        OP_NOT: state_q <= ALUX;
                        OP_HLT: state_q <= HALT;
                        OP_JMP: begin
                            pc_q    <= operand_s;
                            state_q <= FETCH;
                        end
                        OP_JN: begin
                            if (q_N) begin
                                pc_q <= operand_s;
                            end
                            state_q <= FETCH;
                        end
                        OP_JZ: begin
                            if (q_Z) begin
                                pc_q <= operand_s;
                            end
                            state_q <= FETCH;
                        end
                        default: state_q <= FETCH;
                    endcase
                end
                MEMADDR: begin
                    state_q <= MEMEXEC;
                end
                MEMEXEC, STORE, ALUX: begin
                    state_q <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of the datapath controls from state, PC and IR
    always_comb begin
        we_MEM     = 1'b0;
        write_AC   = 1'b0;
        writeNZ    = 1'b0;
        select_ULA = ULA_PASSY;
        addr       = 16'h0000;
        case (state_q)
            FETCH, LOADIR: begin
                addr = 16'(pc_q);
            end
            MEMADDR: begin
                addr = 16'(operand_s);
            end
            MEMEXEC: begin
                addr       = 16'(operand_s);
                select_ULA = ula_sel_for(opcode_s);
                write_AC   = 1'b1;
                writeNZ    = 1'b1;
            end
            STORE: begin
                addr   = 16'(operand_s);
                we_MEM = 1'b1;
            end
            ALUX: begin
                select_ULA = ULA_NOT;
                write_AC   = 1'b1;
                writeNZ    = 1'b1;
            end
            default: begin
                addr = 16'h0000;
            end
        endcase
    end

    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: a memory + accumulator datapath environment,
// an instruction-level reference interpreter feeding a scoreboard queue,
// and a monitor that checks every store and every halt against it.
module tb_unidade_controle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, run_w;
    logic [15:0] q_mem;
    logic        q_n, q_z;
    logic        we_mem, write_ac, write_nz, halted;
    logic [15:0] addr, ir;
    logic [2:0]  sel;
    logic [11:0] pc;

    unidade_controle #(.ADDR_WIDTH(12), .START_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .run(run), .q_MEM(q_mem), .q_N(q_n), .q_Z(q_z),
        .we_MEM(we_mem), .addr(addr), .write_AC(write_ac), .select_ULA(sel),
        .writeNZ(write_nz), .halted(halted), .pc_q(pc), .ir_q(ir)
    );

    // Small instance for the PC wrap case: 4-bit PC starting at 15
    logic [15:0] w_q, w_addr, w_ir;
    logic        w_we, w_wac, w_wnz, w_halted;
    logic [2:0]  w_sel;
    logic [3:0]  w_pc;

    unidade_controle #(.ADDR_WIDTH(4), .START_ADDR(15)) u_wrap (
        .clk(clk), .reset(reset), .run(run_w), .q_MEM(w_q), .q_N(1'b0), .q_Z(1'b0),
        .we_MEM(w_we), .addr(w_addr), .write_AC(w_wac), .select_ULA(w_sel),
        .writeNZ(w_wnz), .halted(w_halted), .pc_q(w_pc), .ir_q(w_ir)
    );

    // mem[0] = HLT, every other word = NOP
    always @(posedge clk) w_q <= (w_addr == 16'h0000) ? 16'hF000 : 16'h0000;

    // ---------------- environment: memory and datapath ----------------
    logic [15:0] mem [0:4095];
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] ac, alu_r;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (we_mem) mem[addr[11:0]] <= ac;
        q_mem <= mem[addr[11:0]];
    end

    always_comb begin
        case (sel)
            3'b000:  alu_r = q_mem;
            3'b001:  alu_r = ac + q_mem;
            3'b010:  alu_r = ac | q_mem;
            3'b011:  alu_r = ac & q_mem;
            3'b100:  alu_r = ~ac;
            3'b101:  alu_r = ac - q_mem;
            default: alu_r = q_mem;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            ac <= 16'h0000; q_n <= 1'b0; q_z <= 1'b0;
        end else begin
            if (write_ac) ac <= alu_r;
            if (write_nz) begin
                q_n <= alu_r[15];
                q_z <= (alu_r == 16'h0000);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_halt;
        int          a;
        logic [15:0] d;
        logic        n;
        logic        z;
        int          cyc;
    } ev_t;

    ev_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model_mem [0:4095];
    logic [15:0] img [0:31];
    logic [15:0] dimg [0:15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Instruction-level interpreter: pushes every store and the final halt
    task automatic run_model();
        int          p, cyc;
        logic [15:0] a, iw;
        logic        n, z;
        logic [3:0]  op;
        logic [11:0] od;
        ev_t         e;
        p = 0; a = 16'h0000; n = 1'b0; z = 1'b0; cyc = 0;
        for (int step = 0; step < 1000; step++) begin
            iw = model_mem[p];
            p  = (p + 1) % 4096;
            op = iw[15:12];
            od = iw[11:0];
            if (op == 4'h1) begin
                e.is_halt = 1'b0; e.a = int'(od); e.d = a; e.n = 1'b0; e.z = 1'b0; e.cyc = 0;
                sb_q.push_back(e);
                model_mem[od] = a;
                cyc += 4;
            end else if (op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'h5 || op == 4'h7) begin
                if (op == 4'h2) a = model_mem[od];
                else if (op == 4'h3) a = a + model_mem[od];
                else if (op == 4'h4) a = a | model_mem[od];
                else if (op == 4'h5) a = a & model_mem[od];
                else a = a - model_mem[od];
                n = a[15]; z = (a == 16'h0000);
                cyc += 5;
            end else if (op == 4'h6) begin
                a = ~a; n = a[15]; z = (a == 16'h0000);
                cyc += 4;
            end else if (op == 4'hF) begin
                cyc += 3;
                e.is_halt = 1'b1; e.a = p; e.d = a; e.n = n; e.z = z; e.cyc = cyc;
                sb_q.push_back(e);
                return;
            end else begin
                if (op == 4'h8 || (op == 4'h9 && n) || (op == 4'hA && z)) p = int'(od);
                cyc += 3;
            end
        end
    endtask

    // Monitor: one sample per cycle, #1 after the rising edge
    initial begin : monitor
        int  cnt;
        bit  active;
        ev_t e;
        cnt = 0; active = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                active = 1'b0;
            end else begin
                if (active) cnt++;
                if (!active && run && !halted) begin
                    active = 1'b1; cnt = 0;
                end
                if (we_mem) begin
                    if (sb_q.size() == 0 || sb_q[0].is_halt) begin
                        n_checks++; n_fail++;
                        $display("FAIL store_unexpected actual_addr=%0h actual_data=%0h required=no_store", addr, ac);
                    end else begin
                        e = sb_q.pop_front();
                        chk("store_addr", 32'(addr), 32'(e.a));
                        chk("store_data", 32'(ac), 32'(e.d));
                    end
                end
                if (halted && active) begin
                    active = 1'b0;
                    if (sb_q.size() == 0 || !sb_q[0].is_halt) begin
                        n_checks++; n_fail++;
                        $display("FAIL halt_early actual=halted required=pending_%0d_events", sb_q.size());
                    end else begin
                        e = sb_q.pop_front();
                        chk("halt_pc", 32'(pc), 32'(e.a));
                        chk("halt_cycles", 32'(cnt), 32'(e.cyc));
                        chk("halt_ac", 32'(ac), 32'(e.d));
                        chk("halt_n", 32'(q_n), 32'(e.n));
                        chk("halt_z", 32'(q_z), 32'(e.z));
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic load_word(input int a, input logic [15:0] d);
        model_mem[a] = d;
        ld_en = 1'b1; ld_addr = 12'(a); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Holds reset while the image is written into both memories
    task automatic load_image();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) load_word(i, img[i]);
        for (int i = 0; i < 16; i++) load_word(256 + i, dimg[i]);
    endtask

    task automatic clear_image();
        for (int i = 0; i < 32; i++) img[i] = 16'h0000;
        for (int i = 0; i < 16; i++) dimg[i] = 16'h0000;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Releases reset, runs the model, starts the DUT and waits for HALT
    task automatic run_prog(input string nm, output bit saw3);
        int i;
        saw3 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        run_model();
        pulse_run();
        for (i = 0; i < 2000; i++) begin
            if (addr == 16'h0003) saw3 = 1'b1;
            if (halted) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk({nm, "_halted"}, 32'(halted), 32'd1);
        chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin : driver
        bit          saw3;
        int          cnt, nins;
        logic [3:0]  op;
        logic [11:0] od;
        logic [11:0] pc_hold;

        reset = 1'b1; run = 1'b0; run_w = 1'b0;
        ld_en = 1'b0; ld_addr = 12'h000; ld_data = 16'h0000;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_we", 32'(we_mem), 32'd0);
        chk("rst_wrap_pc", 32'(w_pc), 32'd15);

        // idle: nothing moves for 10 cycles without run
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctrl", {11'd0, we_mem, write_ac, write_nz, sel, halted, addr},
                32'd0);
            chk("idle_pc", 32'(pc), 32'd0);
        end

        // PC wrap: NOP at 15, PC wraps to 0, HLT there
        pulse_run_w();
        cnt = 0;
        while (!w_halted && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("wrap_cycles", 32'(cnt), 32'd6);
        chk("wrap_pc", 32'(w_pc), 32'd1);
        chk("wrap_ir", 32'(w_ir), 32'h0000F000);

        // load / add / store
        clear_image();
        img[0] = 16'h2010; img[1] = 16'h3011; img[2] = 16'h1012; img[3] = 16'hF000;
        img[16] = 16'h0005; img[17] = 16'h0007;
        load_image();
        run_prog("las", saw3);
        chk("las_mem12", 32'(mem[12'h012]), 32'h0000000C);

        // HLT ignores run
        pc_hold = pc;
        pulse_run();
        repeat (4) @(negedge clk);
        chk("halt_ign_run", 32'(halted), 32'd1);
        chk("halt_ign_pc", 32'(pc), 32'(pc_hold));

        // subtract to zero and JZ over addresses 3 and 4
        clear_image();
        img[0] = 16'h2010; img[1] = 16'h7010; img[2] = 16'hA005;
        img[3] = 16'h1100; img[4] = 16'h1101; img[5] = 16'hF000;
        img[16] = 16'h1234;
        load_image();
        run_prog("jz", saw3);
        chk("jz_no_addr3", 32'(saw3), 32'd0);

        // JN taken (1-2 < 0) and not taken (2-1 > 0)
        for (int k = 0; k < 2; k++) begin
            clear_image();
            img[0] = 16'h2010; img[1] = 16'h7011; img[2] = 16'h9008;
            img[3] = 16'hF000; img[8] = 16'hF000;
            img[16] = (k == 0) ? 16'h0001 : 16'h0002;
            img[17] = (k == 0) ? 16'h0002 : 16'h0001;
            load_image();
            run_prog("jn", saw3);
            chk("jn_final_pc", 32'(pc), (k == 0) ? 32'd9 : 32'd4);
        end

        // reset in the STORE cycle
        clear_image();
        img[0] = 16'h1100; img[1] = 16'hF000;
        load_image();
        reset = 1'b0;
        @(negedge clk);
        run_model();
        pulse_run();
        cnt = 0;
        while (!we_mem && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_store_seen", 32'(we_mem), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we", 32'(we_mem), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        chk("abort_pending", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        load_image();
        run_prog("rerun", saw3);

        // randomized programs with forward-only jumps
        for (int t = 0; t < 40; t++) begin
            clear_image();
            nins = $urandom_range(4, 16);
            for (int i = 0; i < nins - 1; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h8 || op == 4'h9 || op == 4'hA)
                    od = 12'($urandom_range(i + 1, nins - 1));
                else
                    od = 12'h100 + 12'($urandom_range(0, 15));
                img[i] = {op, od};
            end
            img[nins - 1] = 16'hF000;
            for (int i = 0; i < 16; i++) dimg[i] = 16'($urandom);
            load_image();
            run_prog("rand", saw3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    task automatic pulse_run_w();
        run_w = 1'b1;
        @(negedge clk);
        run_w = 1'b0;
    endtask

endmodule
